uart_echo_ctrl: RTL and testbench

UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

---
 rtl/uart_echo_ctrl_pkg.sv | 23 ++
 rtl/uart_echo_ctrl_timer.sv | 31 +++
 rtl/uart_echo_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_echo_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_ctrl_pkg.sv
// Shared definitions for the UART echo controller: FSM states, failure codes,
// default timeout and a saturating counter helper.
package uart_echo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ECHO = 2'd2,
    REPORT    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_PARITY   = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_echo_ctrl_timer.sv
// Echo timeout down-counter: load starts a new window, expired is high once
// the count has run down to zero.
module uart_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded on the tx_start cycle, so reaching zero lands exactly TIMEOUT_CYCLES later.
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/uart_echo_ctrl.sv
// Sends a byte, waits for its echo, retries on timeout/mismatch/parity error.
// Optional statistics counters are built only when ECHO_STATS_EN is defined.
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_parity_error,
  output logic        done,
  output logic        ok,
  output logic [1:0]  err_code,
  output logic [3:0]  retries,
  output logic [15:0] fail_count,
  output logic [15:0] retry_total
);

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        ok_q, ok_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  retries_q, retries_d;

  logic        timer_load;
  logic        timer_expired;
  logic        attempt_fail;
  logic        echo_ok;
  logic [1:0]  cause;
  logic        can_retry;

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .enable  (state_q == WAIT_ECHO),
    .expired (timer_expired)
  );

  assign can_retry = (retries_q < 4'(MAX_RETRIES));

  // A received byte outranks a simultaneous timeout.
  always_comb begin
    attempt_fail = 1'b0;
    echo_ok      = 1'b0;
    cause        = ERR_NONE;
    if (state_q == WAIT_ECHO) begin
      if (rx_done) begin
        if (rx_parity_error) begin
          attempt_fail = 1'b1;
          cause        = ERR_PARITY;
        end else if (rx_data != data_q) begin
          attempt_fail = 1'b1;
          cause        = ERR_MISMATCH;
        end else begin
          echo_ok = 1'b1;
        end
      end else if (timer_expired) begin
        attempt_fail = 1'b1;
        cause        = ERR_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ok_d       = ok_q;
    err_d      = err_q;
    retries_d  = retries_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d    = cmd_data;
          retries_d = 4'd0;
          ok_d      = 1'b0;
          err_d     = ERR_NONE;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          timer_load = 1'b1;
          state_d    = WAIT_ECHO;
        end
      end
      WAIT_ECHO: begin
        if (echo_ok) begin
          ok_d    = 1'b1;
          err_d   = ERR_NONE;
          state_d = REPORT;
        end else if (attempt_fail) begin
          err_d = cause;
          if (can_retry) begin
            retries_d = retries_q + 4'd1;
            state_d   = SEND;
          end else begin
            ok_d    = 1'b0;
            state_d = REPORT;
          end
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= 8'd0;
      ok_q      <= 1'b0;
      err_q     <= ERR_NONE;
      retries_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      retries_q <= retries_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign tx_start  = (state_q == SEND) && !tx_busy;
  assign tx_data   = data_q;
  assign done      = (state_q == REPORT);
  assign ok        = ok_q;
  assign err_code  = err_q;
  assign retries   = retries_q;

`ifdef ECHO_STATS_EN
  logic [15:0] fail_count_q;
  logic [15:0] retry_total_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_count_q  <= 16'd0;
      retry_total_q <= 16'd0;
    end else begin
      if (attempt_fail && !can_retry) fail_count_q  <= sat_inc16(fail_count_q);
      if (attempt_fail && can_retry)  retry_total_q <= sat_inc16(retry_total_q);
    end
  end

  assign fail_count  = fail_count_q;
  assign retry_total = retry_total_q;
`else
  assign fail_count  = 16'd0;
  assign retry_total = 16'd0;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl with TIMEOUT_CYCLES=64, MAX_RETRIES=2.
module tb_uart_echo_ctrl;

  localparam int T  = 64;
  localparam int MR = 2;
`ifdef ECHO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_parity_error;
  logic        done;
  logic        ok;
  logic [1:0]  err_code;
  logic [3:0]  retries;
  logic [15:0] fail_count;
  logic [15:0] retry_total;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int cyc = 0;
  int tx_cnt = 0;
  int last_tx = 0;
  int prev_tx = 0;
  int done_cnt = 0;
  int acc_cyc = 0;

  uart_echo_ctrl #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .rx_data         (rx_data),
    .rx_done         (rx_done),
    .rx_parity_error (rx_parity_error),
    .done            (done),
    .ok              (ok),
    .err_code        (err_code),
    .retries         (retries),
    .fail_count      (fail_count),
    .retry_total     (retry_total)
  );

  always #5 clk = ~clk;

  // Cycle index and pulse bookkeeping; cyc equals the index of the cycle in progress.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start === 1'b1) begin
      tx_cnt  <= tx_cnt + 1;
      prev_tx <= last_tx;
      last_tx <= cyc;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic echo(input logic [7:0] b, input logic par);
    rx_data         = b;
    rx_parity_error = par;
    rx_done         = 1'b1;
    step(1);
    rx_done         = 1'b0;
    rx_parity_error = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    int tx_before;
    int done_before;
    reset = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b0; tx_busy = 1'b0;
    rx_data = 8'h00; rx_done = 1'b0; rx_parity_error = 1'b0;
    step(3);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_ok", ok, 1'b0);
    chk("rst_err", err_code, 2'b00);
    chk("rst_retries", retries, 4'd0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_fail_count", fail_count, 16'd0);
    chk("rst_retry_total", retry_total, 16'd0);
    reset = 1'b1;
    step(1);
    chk("post_rst_ready", cmd_ready, 1'b1);

    // Stray byte while idle must not start anything.
    echo(8'h5A, 1'b0);
    chk("stray_idle_done", done, 1'b0);
    chk("stray_idle_ready", cmd_ready, 1'b1);
    chk("stray_idle_tx", tx_start, 1'b0);

    // Clean echo 40 cycles after tx_start.
    accept(8'h5A);
    chk("t1_tx_start", tx_start, 1'b1);
    chk("t1_tx_data", tx_data, 8'h5A);
    chk("t1_ready_low", cmd_ready, 1'b0);
    step(1);
    chk("t1_tx_cycle", last_tx - acc_cyc, 1);
    step(39);
    echo(8'h5A, 1'b0);
    chk("t1_done", done, 1'b1);
    chk("t1_ok", ok, 1'b1);
    chk("t1_err", err_code, 2'b00);
    chk("t1_retries", retries, 4'd0);
    chk("t1_latency", cyc - acc_cyc, 42);
    step(1);
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_ok_hold", ok, 1'b1);
    chk("t1_ready_back", cmd_ready, 1'b1);

    // No echo at all: three attempts, each timing out.
    tx_before = tx_cnt;
    accept(8'h3C);
    wait_done("t2", 400);
    chk("t2_latency", cyc - acc_cyc, 196);
    chk("t2_ok", ok, 1'b0);
    chk("t2_err", err_code, 2'b01);
    chk("t2_retries", retries, 4'd2);
    chk("t2_tx_pulses", tx_cnt - tx_before, 3);
    chk("t2_tx_spacing", last_tx - prev_tx, T + 1);
    step(1);
    chk("t2_fail_count", fail_count, STATS ? 16'd1 : 16'd0);
    chk("t2_retry_total", retry_total, STATS ? 16'd2 : 16'd0);

    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    chk("rst2_fail_count", fail_count, 16'd0);

    // Wrong echo first, correct echo on the resend.
    accept(8'h5A);
    step(1);
    echo(8'h5B, 1'b0);
    chk("t3_retries_mid", retries, 4'd1);
    chk("t3_err_mid", err_code, 2'b10);
    chk("t3_resend", tx_start, 1'b1);
    chk("t3_tx_data", tx_data, 8'h5A);
    step(1);
    echo(8'h5A, 1'b0);
    chk("t3_done", done, 1'b1);
    chk("t3_ok", ok, 1'b1);
    chk("t3_retries", retries, 4'd1);
    step(1);
    chk("t3_retry_total", retry_total, STATS ? 16'd1 : 16'd0);

    // Parity error on the final attempt.
    accept(8'hA5);
    step(1);
    echo(8'h00, 1'b0);
    step(1);
    echo(8'h11, 1'b0);
    step(1);
    echo(8'hA5, 1'b1);
    chk("t4_done", done, 1'b1);
    chk("t4_ok", ok, 1'b0);
    chk("t4_err", err_code, 2'b11);
    chk("t4_retries", retries, 4'd2);
    step(1);
    chk("t4_fail_count", fail_count, STATS ? 16'd1 : 16'd0);
    chk("t4_retry_total", retry_total, STATS ? 16'd3 : 16'd0);

    // Busy transmitter for 20 cycles, then echo on the exact timeout cycle.
    tx_busy = 1'b1;
    tx_before = tx_cnt;
    accept(8'h5A);
    chk("t5_busy_no_tx", tx_start, 1'b0);
    chk("t5_busy_ready", cmd_ready, 1'b0);
    echo(8'h5A, 1'b0);
    step(18);
    tx_busy = 1'b0;
    step(1);
    chk("t5_tx_cycle", last_tx - acc_cyc, 20);
    chk("t5_tx_pulses", tx_cnt - tx_before, 1);
    step(T - 1);
    echo(8'h5A, 1'b0);
    chk("t5_done", done, 1'b1);
    chk("t5_ok", ok, 1'b1);
    chk("t5_retries", retries, 4'd0);
    chk("t5_latency", cyc - acc_cyc, 85);
    step(1);

    // Reset in the middle of an echo wait.
    accept(8'hC3);
    step(1);
    echo(8'h00, 1'b0);
    step(6);
    chk("t6_pre_retries", retries, 4'd1);
    done_before = done_cnt;
    reset = 1'b0;
    step(1);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_tx_start", tx_start, 1'b0);
    chk("t6_rst_ok", ok, 1'b0);
    chk("t6_rst_err", err_code, 2'b00);
    chk("t6_rst_retries", retries, 4'd0);
    chk("t6_rst_tx_data", tx_data, 8'h00);
    chk("t6_rst_fail_count", fail_count, 16'd0);
    chk("t6_rst_retry_total", retry_total, 16'd0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("t6_ready_after", cmd_ready, 1'b1);
    chk("t6_done_after", done, 1'b0);
    step(2);
    chk("t6_no_done_pulse", done_cnt - done_before, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
